// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor/accumulator: resolves one CHUNK-bit slice per cycle,
// carrying between slices in a register, and commits the full result to Sout.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             acc,
  input  logic             clr,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sout,
  output logic             Co,
  output logic             Ov,
  output logic             dbg_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  // Handshake: start is accepted only in IDLE (busy=0); busy then stays high for
  // exactly N cycles; done pulses one cycle as the result lands in Sout/Co/Ov.
  // A start seen during busy is dropped, never queued.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] opa, opb, res, res_nxt;
  logic             carry;
  logic             last;

  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_sl, c_msb;

  assign last = (k == KW'(N - 1));
  assign a_sl = opa[k*CHUNK +: CHUNK];
  assign b_sl = opb[k*CHUNK +: CHUNK];
  assign {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
  // Carry into the top bit of the slice; only meaningful for Ov on the last chunk.
  assign c_msb = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1];

  always_comb begin
    res_nxt = res;
    res_nxt[k*CHUNK +: CHUNK] = s_sl;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state == RUN);
    dbg_state = state;
  end

  // Datapath: operand latch, per-chunk accumulation, commit and clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      Sout  <= '0;
      Co    <= 1'b0;
      Ov    <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          opa   <= acc ? Sout : Ain;
          opb   <= sub ? ~Bin : Bin;
          carry <= sub | Ci;
          k     <= '0;
        end else if (clr) begin
          Sout <= '0;
          Co   <= 1'b0;
          Ov   <= 1'b0;
        end
      end else begin
        res   <= res_nxt;
        carry <= c_sl;
        k     <= k + KW'(1);
        if (last) begin
          Sout <= res_nxt;
          Co   <= c_sl;
          Ov   <= c_msb ^ c_sl;
          done <= 1'b1;
          k    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed-vector bench for seq_chunk_adder (WIDTH=32, CHUNK=8, N=4) with
// hand-computed expectations.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, sub, acc, clr, ci;
  logic [31:0] ain, bin;
  logic        busy, done, co, ov, dbg_state;
  logic [31:0] sout;

  int n_cmp = 0;
  int n_bad = 0;

  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .acc(acc), .clr(clr),
    .Ain(ain), .Bin(bin), .Ci(ci), .busy(busy), .done(done), .Sout(sout),
    .Co(co), .Ov(ov), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done; reports cycles to done and busy cycles seen.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic ac, input logic c, output int lat, output int busy_cnt);
    ain = a; bin = b; sub = s; acc = ac; ci = c; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, busy_cnt);
  endtask

  int lat, bc;
  int cyc, nd;
  int dt[3];

  initial begin
    rst_n = 1'b0; start = 0; sub = 0; acc = 0; clr = 0; ci = 0; ain = 0; bin = 0;
    repeat (2) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sout", sout, 32'd0);
    check("rst_co_ov", {30'd0, co, ov}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Full carry ripple across every chunk
    run_op(32'hFFFF_FFFF, 32'h1, 0, 0, 0, lat, bc);
    check("ripple_sout", sout, 32'h0);
    check("ripple_co_ov", {30'd0, co, ov}, 32'b10);
    check("ripple_latency", lat, 32'd4);
    check("ripple_busy_cycles", bc, 32'd4);
    check("ripple_done_busy_excl", {31'd0, busy}, 32'd0);
    tick();
    check("ripple_done_pulse", {31'd0, done}, 32'd0);

    run_op(32'h0000_00FF, 32'h0, 0, 0, 1, lat, bc);
    check("ci_sout", sout, 32'h0000_0100);
    check("ci_co", {31'd0, co}, 32'd0);

    // Ci must be ignored on subtract
    run_op(32'd5, 32'd7, 1, 0, 1, lat, bc);
    check("sub_neg_sout", sout, 32'hFFFF_FFFE);
    check("sub_neg_co_ov", {30'd0, co, ov}, 32'b00);

    run_op(32'h7FFF_FFFF, 32'h1, 0, 0, 0, lat, bc);
    check("ovf_add_sout", sout, 32'h8000_0000);
    check("ovf_add_co_ov", {30'd0, co, ov}, 32'b01);

    run_op(32'h8000_0000, 32'h1, 1, 0, 0, lat, bc);
    check("ovf_sub_sout", sout, 32'h7FFF_FFFF);
    check("ovf_sub_co_ov", {30'd0, co, ov}, 32'b11);

    // Clear, then back-to-back accumulate with start held high
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_sout", sout, 32'h0);
    check("clr_co_ov", {30'd0, co, ov}, 32'd0);
    ain = 32'hDEAD_0000; bin = 32'h10; sub = 0; acc = 1; ci = 0; start = 1'b1;
    cyc = 0; nd = 0;
    while (nd < 3 && cyc < 40) begin
      tick();
      cyc++;
      if (done) begin
        dt[nd] = cyc;
        nd++;
        if (nd == 3) start = 1'b0;
      end
    end
    start = 1'b0; acc = 0;
    check("acc_done_count", nd, 32'd3);
    check("acc_gap1", dt[1] - dt[0], 32'd5);
    check("acc_gap2", dt[2] - dt[1], 32'd5);
    check("acc_sout", sout, 32'h0000_0030);
    tick();
    check("acc_no_extra_op", {31'd0, busy}, 32'd0);

    // start re-pulsed during RUN is ignored
    ain = 32'h1111_1111; bin = 32'h2222_2222; start = 1'b1;
    tick();
    ain = 32'hFFFF_FFFF; bin = 32'hFFFF_FFFF; start = 1'b1;
    tick();
    start = 1'b0;
    check("repulse_sout_stable", sout, 32'h0000_0030);
    wait_done(lat, bc);
    check("repulse_sout", sout, 32'h3333_3333);
    check("repulse_co", {31'd0, co}, 32'd0);
    tick();
    check("repulse_not_queued", {31'd0, busy}, 32'd0);

    // start and clr together: start wins
    ain = 32'h1; bin = 32'h2; start = 1'b1; clr = 1'b1;
    tick();
    start = 1'b0; clr = 1'b0;
    check("startclr_busy", {31'd0, busy}, 32'd1);
    check("startclr_sout_kept", sout, 32'h3333_3333);
    wait_done(lat, bc);
    check("startclr_sout", sout, 32'h3);

    // Asynchronous reset mid-operation
    ain = 32'h1234_5678; bin = 32'h1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_sout", sout, 32'h0);
    check("midrst_co_ov", {30'd0, co, ov}, 32'd0);
    nd = 0;
    repeat (2) begin
      tick();
      if (done) nd++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      tick();
      if (done) nd++;
    end
    check("midrst_no_done", nd, 32'd0);
    run_op(32'h1, 32'h2, 0, 0, 0, lat, bc);
    check("post_rst_sout", sout, 32'h3);
    check("post_rst_latency", lat, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
# seq_chunk_adder

Parametrised multi-cycle adder/subtractor/accumulator. It is the sequential successor to the team's 8-bit ripple-carry adder. Each cycle it resolves one CHUNK-bit slice of a WIDTH-bit operation and carries between slices in a register, so wide adds close timing without a full-width carry chain. It sits in the datapath as a start/done coprocessor with its own result register, which the accumulate mode reuses as an operand.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK and ≥ CHUNK
- CHUNK, 8, bits resolved per cycle; N = WIDTH/CHUNK cycles per operation

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a new operation (sampled only while idle)
- sub  in  1  0 = add, 1 = subtract (A − B)
- acc  in  1  1 = A operand is the current Sout instead of Ain
- clr  in  1  synchronous clear of Sout/Co/Ov (honoured only while idle)
- Ain  in  WIDTH  operand A
- Bin  in  WIDTH  operand B
- Ci  in  1  carry-in (add only; ignored when sub=1)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse: result just committed
- Sout  out  WIDTH  result register
- Co  out  1  carry-out; for sub, 1 = no borrow (A ≥ B unsigned)
- Ov  out  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN. Chunk index k counts 0..N−1 in RUN.
- IDLE and start=1:
  - Latch opA = acc ? Sout : Ain.
  - Latch opB = sub ? ~Bin : Bin.
  - Latch carry = sub ? 1 : Ci.
  - Set k = 0, go to RUN.
- IDLE and start=0 and clr=1: Sout = 0, Co = 0, Ov = 0. If start and clr are both high, start wins and clr is ignored.
- RUN, each cycle:
  - {c, s} = opA[k·CHUNK +: CHUNK] + opB[k·CHUNK +: CHUNK] + carry.
  - Write s into the internal result slice k and register c into carry.
  - At k = N−1, also capture the carry into the MSB (bit WIDTH−1) for Ov.
- RUN at k = N−1: commit the internal result to Sout, set Co = final carry, set Ov = carry-into-MSB XOR final carry. Pulse done, go to IDLE.
- Sout, Co and Ov change only at commit, at clr, or at reset. They are stable throughout RUN.
- start, sub, acc, Ain, Bin and Ci are don't-care while busy. start during RUN is ignored, not queued.
- Arithmetic is modulo 2^WIDTH. Co and Ov are the only indication of wrap-around.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, k = 0, busy = 0, done = 0, Sout = 0, Co = 0, Ov = 0. Internal operand, carry and result registers are cleared.
- Reset asserted mid-RUN aborts the operation: no done pulse, outputs go to reset values immediately.
- Start sampled at edge E0:
  - busy = 1 from E0 until edge EN (N edges later).
  - At EN: Sout/Co/Ov updated, busy = 0, done = 1.
  - At EN+1: done = 0, unless a new operation completes there, which is impossible.
- Latency: N cycles from the start edge to valid result. With N = 1 (CHUNK = WIDTH), the result is valid one edge after start.
- done and busy are never high together. done is high for exactly one cycle per completed operation.
- Back-to-back: start may be held high during the done cycle. It is accepted at EN+1, giving sustained throughput of one operation per N+1 cycles. In acc mode that operation uses the Sout just committed.

## Test plan
(WIDTH = 32, CHUNK = 8, N = 4)
- Add with carry ripple: Ain = 0xFFFFFFFF, Bin = 0x00000001, Ci = 0, start → after 4 edges Sout = 0x00000000, Co = 1, Ov = 0; busy high for exactly 4 cycles; done high 1 cycle.
- Ci and inter-chunk carry: Ain = 0x000000FF, Bin = 0x00000000, Ci = 1 → Sout = 0x00000100, Co = 0. Then sub = 1, Ain = 5, Bin = 7, Ci = 1 (must be ignored) → Sout = 0xFFFFFFFE, Co = 0, Ov = 0.
- Signed overflow: Ain = 0x7FFFFFFF + Bin = 0x00000001 → Sout = 0x80000000, Co = 0, Ov = 1. Then sub = 1, Ain = 0x80000000, Bin = 1 → Sout = 0x7FFFFFFF, Co = 1, Ov = 1.
- Accumulate: clr pulse → Sout = 0. Then three operations with acc = 1, Bin = 0x10, start held high across done cycles → done pulses 5 cycles apart; final Sout = 0x00000030.
- Protocol corners:
  - start re-pulsed during RUN with different Ain/Bin → ignored; result matches the first operands; Sout unchanged until commit.
  - start and clr high together in IDLE → operation runs, no clear.
- Reset mid-operation: rst_n low 2 cycles after start (asynchronous, between edges) → busy, done, Sout, Co and Ov all 0 immediately; no done pulse. A subsequent start of 0x1 + 0x2 → Sout = 0x3.
